seq_mul_reconstruct: RTL and testbench

//  Inverse of the 2W/W array divider: rebuilds the dividend n = q*d + r from a quotient,

---
 rtl/seq_mul_reconstruct.sv | 135 +++++++++++++
 tb/tb_seq_mul_reconstruct.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_reconstruct.sv
// seq_mul_reconstruct: rebuilds a dividend n = q*d + r with a shift-add multiplier.
// Each clock in RUN adds one partial product. Operands are taken on a valid/ready
// handshake, and the result is offered on a second valid/ready pair.
// The optional approximate low-column adder is enabled by defining APPROX_LOW_EN.
// With it enabled, the low APPROX_COLS columns are OR-combined and their carries
// are dropped, which matches the approximate low cells of the divider arrays.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | W shift-add steps, one partial product per clock
// DONE  | result held on n with out_valid high until out_ready
module seq_mul_reconstruct #(
    parameter int W           = 8,
    parameter int APPROX_COLS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     q,
    input  logic [W-1:0]     d,
    input  logic [W-1:0]     r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   n,
    output logic             busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

`ifdef APPROX_LOW_EN
    localparam bit APPROX_EN = 1'b1;
`else
    localparam bit APPROX_EN = 1'b0;
`endif

    // Columns below APPROX_COLS form the carry-free low part of the approximate adder.
    localparam logic [2*W-1:0] LO_MASK =
        (APPROX_COLS == 0) ? '0 : ({(2*W){1'b1}} >> (2*W - APPROX_COLS));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]   n_q, n_d;
    logic [2*W-1:0]   sum_exact, sum_approx, sum;

    // Step adder: exact sum, or split sum with carry-free OR in the low columns.
    always_comb begin
        sum_exact  = acc_q + mcand_q;
        sum_approx = (((acc_q & ~LO_MASK) + (mcand_q & ~LO_MASK)) & ~LO_MASK)
                   | ((acc_q | mcand_q) & LO_MASK);
        sum        = APPROX_EN ? sum_approx : sum_exact;
    end

    // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    acc_d    = {{W{1'b0}}, r};
                    mcand_d  = {{W{1'b0}}, d};
                    mplier_d = q;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = sum;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Capture the final sum so n survives the next operand load.
                    n_d     = mplier_q[0] ? sum : acc_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: accumulator, shifted operands, step counter, result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            n_q      <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign n         = n_q;

endmodule

// File: tb/tb_seq_mul_reconstruct.sv
// Scoreboard bench for seq_mul_reconstruct: the driver pushes model results at
// acceptance and an independent monitor pops them on each output handshake.
module tb_seq_mul_reconstruct;

    localparam int W = 8;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   q, d, r;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] n;
    logic           busy;

    seq_mul_reconstruct #(.W(W), .APPROX_COLS(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .d         (d),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n         (n),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int             checks = 0;
    int             errors = 0;
    int             cyc = 0;
    int             accept_cyc = 0;
    int             hs_cyc = 0;
    bit             have_accept = 0;
    bit             auto_ready = 0;
    logic [2*W-1:0] sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: dividend = q*d + r; the approximate build sums partial products
    // with the low C columns OR-combined and no carry out of them.
    function automatic logic [2*W-1:0] approx_add(input logic [2*W-1:0] a, input logic [2*W-1:0] b);
        logic [2*W-1:0] one = 1;
        logic [2*W-1:0] lomask;
        logic [2*W-1:0] hi;
        lomask = (one << C) - 1'b1;
        hi = ((a >> C) + (b >> C)) << C;
        return hi | ((a | b) & lomask);
    endfunction

    function automatic logic [2*W-1:0] ref_n(input logic [W-1:0] qq, input logic [W-1:0] dd,
                                            input logic [W-1:0] rr);
`ifdef APPROX_LOW_EN
        logic [2*W-1:0] acc = {{W{1'b0}}, rr};
        logic [2*W-1:0] pp;
        for (int i = 0; i < W; i++) begin
            if (qq[i]) begin
                pp = {{W{1'b0}}, dd} << i;
                acc = approx_add(acc, pp);
            end
        end
        return acc;
`else
        int unsigned full;
        full = int'(qq) * int'(dd) + int'(rr);
        return full[2*W-1:0];
`endif
    endfunction

    initial forever @(posedge clk) cyc++;

    initial forever begin
        @(posedge clk);
        #1;
        if (auto_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Monitor: scoreboard pops, latency, output stability under backpressure.
    initial begin
        bit             prev_ov = 0;
        bit             prev_hs = 0;
        logic [2*W-1:0] prev_n = '0;
        logic [2*W-1:0] exp_n;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_ov = 0;
                prev_hs = 0;
            end else begin
                if (out_valid && !prev_ov && have_accept) begin
                    check("latency", 64'(cyc - accept_cyc), 64'(W));
                    have_accept = 0;
                end
                if (prev_ov && !prev_hs) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_n", 64'(n), 64'(prev_n));
                end
                if (out_valid) check("no_bypass_in_ready", 64'(in_ready), 64'd0);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 64'(out_valid), 64'd0);
                    end else begin
                        exp_n = sb.pop_front();
                        check("result_n", 64'(n), 64'(exp_n));
                    end
                    hs_cyc = cyc + 1;
                end
                prev_ov = out_valid;
                prev_hs = out_valid && out_ready;
                prev_n  = n;
            end
        end
    end

    // Present operands until accepted; push the expected result at the accept edge.
    task automatic issue(input logic [W-1:0] qq, input logic [W-1:0] dd, input logic [W-1:0] rr,
                         input bit use_lit, input logic [2*W-1:0] lit);
        bit ok = 0;
        in_valid = 1'b1;
        q = qq;
        d = dd;
        r = rr;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb.push_back(use_lit ? lit : ref_n(qq, dd, rr));
            #1;
            accept_cyc  = cyc;
            have_accept = 1;
            in_valid = 1'b0;
            q = W'($urandom);
            d = W'($urandom);
            r = W'($urandom);
        end
    endtask

    task automatic wait_ov();
        bit seen = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        bit done = 0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int first_acc;
        bit exact;
`ifdef APPROX_LOW_EN
        exact = 0;
`else
        exact = 1;
`endif
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        q = '0;
        d = '0;
        r = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_n", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed operations, consumer always ready.
        out_ready = 1'b1;
        issue(8'h0F, 8'h10, 8'h05, 1'b1, 16'h00F5);
        @(negedge clk);
        check("busy_in_run", 64'(busy), 64'd1);
        check("in_ready_in_run", 64'(in_ready), 64'd0);
        drain();
        issue(8'hFF, 8'hFF, 8'hFF, exact, 16'hFF00);
        drain();
        issue(8'hA5, 8'h00, 8'h3C, 1'b1, 16'h003C);
        drain();
        issue(8'h00, 8'h77, 8'h81, 1'b1, 16'h0081);
        drain();

        // Back-to-back acceptances are spaced exactly W+2 cycles.
        issue(8'h12, 8'h34, 8'h56, 1'b0, '0);
        first_acc = accept_cyc;
        issue(8'h9A, 8'hBC, 8'hDE, 1'b0, '0);
        check("accept_spacing", 64'(accept_cyc - first_acc), 64'(W + 2));
        drain();

        // Backpressure with a competing in_valid held in DONE.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(8'h3C, 8'h5A, 8'h11, 1'b0, '0);
        in_valid = 1'b1;
        q = 8'h07;
        d = 8'h09;
        r = 8'h02;
        wait_ov();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(8'h07, 8'h09, 8'h02, exact, 16'h0041);
        check("accept_after_hs", 64'(accept_cyc - hs_cyc), 64'd1);
        drain();

        // Reset during RUN aborts the operation.
        issue(8'hC3, 8'h7E, 8'h19, 1'b0, '0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        void'(sb.pop_back());
        have_accept = 0;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_n", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            check("abort_no_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        issue(8'd2, 8'd3, 8'd1, 1'b1, 16'd7);
        drain();

`ifdef APPROX_LOW_EN
        issue(8'd3, 8'd3, 8'd0, 1'b1, 16'h0007);
        drain();
        issue(8'h10, 8'h10, 8'h00, 1'b1, 16'h0100);
        drain();
`endif

        // Randomized traffic with random consumer backpressure and idle gaps.
        auto_ready = 1;
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), (i % 7 == 0) ? '0 : W'($urandom), W'($urandom), 1'b0, '0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        auto_ready = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
